spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_tick.sv | 53 +++++
 rtl/spi_master.sv | 204 ++++++++++++++++++++
 tb/tb_spi_master.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_tick                                                     |
// | Description : Half-period strobe generator for the SPI master. Produces a  |
// |               one-cycle expiry strobe each time the current sck phase has  |
// |               lasted its full length.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk      in   system clock                                               |
// |   rst      in   synchronous active-high reset                              |
// |   i_clear  in   restart the count at zero (transfer accepted)              |
// |   i_run    in   count while a transfer is in flight                        |
// |   o_expire out  current phase ends on this clock edge                      |
// +----------------------------------------------------------------------------+
module spi_tick #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = $clog2(HALF + 1);
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // The count restarts at 0 on an accepted start but reloads to 1 after
    // each expiry, so the first LOW phase is one clock longer than every
    // later phase. That single extra cycle is the fixed start-up latency of
    // a transfer; the counter never exceeds HALF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            if (r_cnt == C_TERM) begin
                r_cnt <= C_ONE;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end

    assign o_expire = i_run && (r_cnt == C_TERM);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master                                                   |
// | Description : Mode-0 SPI master. Shifts one SIZE-bit word out on sdo MSB   |
// |               first while capturing SIZE bits from sdi on sck rising,      |
// |               framed by an active-high chip select.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   SIZE  word length in bits (>= 2)                                         |
// |   HALF  clk cycles per sck half-period (>= 1)                              |
// | Ports                                                                      |
// |   clk    in   system clock                                                 |
// |   rst    in   synchronous active-high reset                                |
// |   start  in   transfer request, honoured only when idle                     |
// |   pdi    in   word to transmit, captured on an accepted start              |
// |   pdo    out  last received word, updated with done                        |
// |   busy   out  transfer in flight                                           |
// |   done   out  one-cycle completion pulse                                   |
// |   sck    out  serial clock, idles low                                      |
// |   sdo    out  serial data out                                              |
// |   sdi    in   serial data in                                               |
// |   scs    out  chip select, active high                                     |
// +----------------------------------------------------------------------------+
module spi_master #(
    parameter int SIZE = 8,
    parameter int HALF = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] pdi,
    output logic [SIZE-1:0] pdo,
    output logic            busy,
    output logic            done,
    output logic            sck,
    output logic            sdo,
    input  logic            sdi,
    output logic            scs
);

    localparam int BIT_W = $clog2(SIZE);
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(SIZE - 1);
    localparam logic [BIT_W-1:0] C_BIT_ONE  = BIT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_END  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOW  = ST_LOW,
        S_HIGH = ST_HIGH,
        S_END  = ST_END
    } state_t;

    state_t            r_state;
    logic              r_sck;
    logic              r_scs;
    logic              r_sdo;
    logic              r_busy;
    logic              r_done;
    logic [SIZE-1:0]   r_tx;
    logic [SIZE-1:0]   r_rx;
    logic [SIZE-1:0]   r_pdo;
    logic [BIT_W-1:0]  r_bit;

    state_t            w_state_nxt;
    logic              w_sck_nxt;
    logic              w_scs_nxt;
    logic              w_sdo_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic [SIZE-1:0]   w_tx_nxt;
    logic [SIZE-1:0]   w_rx_nxt;
    logic [SIZE-1:0]   w_pdo_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic              w_accept;
    logic              w_run;
    logic              w_expire;

    assign w_run = (r_state != S_IDLE);

    spi_tick #(
        .HALF (HALF)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept),
        .i_run    (w_run),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sck   <= 1'b0;
            r_scs   <= 1'b0;
            r_sdo   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_pdo   <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sck   <= w_sck_nxt;
            r_scs   <= w_scs_nxt;
            r_sdo   <= w_sdo_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_pdo   <= w_pdo_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sck_nxt   = r_sck;
        w_scs_nxt   = r_scs;
        w_sdo_nxt   = r_sdo;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_pdo_nxt   = r_pdo;
        w_bit_nxt   = r_bit;
        w_accept    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sck_nxt  = 1'b0;
                w_scs_nxt  = 1'b0;
                w_busy_nxt = 1'b0;
                // Also reached from the done cycle, which is what makes
                // back-to-back transfers possible with start held high.
                if (start) begin
                    w_accept    = 1'b1;
                    w_tx_nxt    = pdi;
                    w_rx_nxt    = '0;
                    w_sdo_nxt   = pdi[SIZE-1];
                    w_scs_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_LOW;
                end
            end

            S_LOW: begin
                // sck rises on this edge; the same edge captures sdi, which
                // the slave has held stable throughout the low phase.
                if (w_expire) begin
                    w_sck_nxt   = 1'b1;
                    w_rx_nxt    = {r_rx[SIZE-2:0], sdi};
                    w_state_nxt = S_HIGH;
                end
            end

            S_HIGH: begin
                if (w_expire) begin
                    w_sck_nxt = 1'b0;
                    if (r_bit == C_BIT_LAST) begin
                        w_state_nxt = S_END;
                    end else begin
                        // Next bit goes out together with the falling sck.
                        w_bit_nxt   = r_bit + C_BIT_ONE;
                        w_tx_nxt    = {r_tx[SIZE-2:0], 1'b0};
                        w_sdo_nxt   = r_tx[SIZE-2];
                        w_state_nxt = S_LOW;
                    end
                end
            end

            S_END: begin
                // Chip select is held through one more low half-period so
                // the slave sees a clean trailing edge before deselect.
                if (w_expire) begin
                    w_scs_nxt   = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_pdo_nxt   = r_rx;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pdo  = r_pdo;
    assign busy = r_busy;
    assign done = r_done;
    assign sck  = r_sck;
    assign sdo  = r_sdo;
    assign scs  = r_scs;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master                                                |
// | Description : Self-checking bench for spi_master. Two instances (8-bit,    |
// |               half=2 and 16-bit, half=1) are compared every cycle against  |
// |               a timeline model derived from the transfer rules, plus       |
// |               directed scenarios with literal expectations.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_master;

    localparam int S8  = 8;
    localparam int H8  = 2;
    localparam int T8  = (2 * S8 + 1) * H8 + 1;
    localparam int S16 = 16;
    localparam int H16 = 1;
    localparam int T16 = (2 * S16 + 1) * H16 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     = 1'b1;
    logic        start8  = 1'b0;
    logic        start16 = 1'b0;
    logic        loop8   = 1'b0;
    logic [7:0]  pdi8    = 8'h00;
    logic [15:0] pdi16   = 16'h0000;
    logic [7:0]  pdo8;
    logic [15:0] pdo16;
    logic        busy8, done8, sck8, sdo8, sdi8, scs8;
    logic        busy16, done16, sck16, sdo16, sdi16, scs16;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    spi_master #(.SIZE(S8), .HALF(H8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .pdi   (pdi8),
        .pdo   (pdo8),
        .busy  (busy8),
        .done  (done8),
        .sck   (sck8),
        .sdo   (sdo8),
        .sdi   (sdi8),
        .scs   (scs8)
    );

    spi_master #(.SIZE(S16), .HALF(H16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .pdi   (pdi16),
        .pdo   (pdo16),
        .busy  (busy16),
        .done  (done16),
        .sck   (sck16),
        .sdo   (sdo16),
        .sdi   (sdi16),
        .scs   (scs16)
    );

    // Mode-0 slave for the 8-bit instance: loads its reply on select, shifts
    // it out on sck falling, captures sdo on sck rising.
    logic [7:0] sl_tx    = 8'h00;
    logic [7:0] sl_rx    = 8'h00;
    int         sl_rises = 0;
    logic       sck8_q   = 1'b0;
    logic       scs8_q   = 1'b0;

    always @(negedge clk) begin
        sck8_q <= sck8;
        scs8_q <= scs8;
        if (scs8 && !scs8_q) begin
            sl_tx    <= 8'h81;
            sl_rises <= 0;
        end else begin
            if (sck8_q && !sck8) sl_tx <= {sl_tx[6:0], 1'b0};
            if (!sck8_q && sck8) begin
                sl_rx    <= {sl_rx[6:0], sdo8};
                sl_rises <= sl_rises + 1;
            end
        end
    end

    assign sdi8  = loop8 ? sdo8 : sl_tx[7];
    assign sdi16 = sdo16;

    // Timeline model: k counts clock edges since the accepting edge; a
    // transfer finishes with done at k == T.
    logic        m8_act = 1'b0, m16_act = 1'b0;
    int          m8_k = 0, m16_k = 0;
    logic [15:0] m8_word = '0, m8_rxw = '0, m8_pdo = '0;
    logic [15:0] m16_word = '0, m16_rxw = '0, m16_pdo = '0;

    always @(posedge clk) begin
        if (rst) begin
            m8_act <= 1'b0; m8_k <= 0; m8_pdo <= '0;
        end else if ((!m8_act || m8_k == T8) && start8) begin
            m8_act  <= 1'b1;
            m8_k    <= 0;
            m8_word <= {8'h00, pdi8};
            m8_rxw  <= loop8 ? {8'h00, pdi8} : 16'h0081;
        end else if (m8_act) begin
            if (m8_k == T8) m8_act <= 1'b0;
            else begin
                m8_k <= m8_k + 1;
                if (m8_k + 1 == T8) m8_pdo <= m8_rxw;
            end
        end

        if (rst) begin
            m16_act <= 1'b0; m16_k <= 0; m16_pdo <= '0;
        end else if ((!m16_act || m16_k == T16) && start16) begin
            m16_act  <= 1'b1;
            m16_k    <= 0;
            m16_word <= pdi16;
            m16_rxw  <= pdi16;
        end else if (m16_act) begin
            if (m16_k == T16) m16_act <= 1'b0;
            else begin
                m16_k <= m16_k + 1;
                if (m16_k + 1 == T16) m16_pdo <= m16_rxw;
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input int S, input int H, input int T,
                             input logic act, input int k,
                             input logic [15:0] word, input logic [15:0] epdo,
                             input logic [15:0] a_pdo, input logic a_busy,
                             input logic a_done, input logic a_sck,
                             input logic a_sdo, input logic a_scs);
        logic e_scs, e_busy, e_done, e_sck;
        int   m, b;
        e_scs = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sck = 1'b0;
        if (act && k < T) begin
            e_scs  = 1'b1;
            e_busy = 1'b1;
            m      = k - (H + 1);
            e_sck  = (m >= 0) && (m < 2 * S * H) && (((m / H) % 2) == 0);
            b      = (m < 0) ? 0 : (m + H) / (2 * H);
            if (b > S - 1) b = S - 1;
            chk1({nm, ".sdo"}, a_sdo, word[S-1-b]);
        end else if (act && k == T) begin
            e_done = 1'b1;
        end
        chk1({nm, ".scs"},  a_scs,  e_scs);
        chk1({nm, ".busy"}, a_busy, e_busy);
        chk1({nm, ".done"}, a_done, e_done);
        chk1({nm, ".sck"},  a_sck,  e_sck);
        chkw({nm, ".pdo"},  a_pdo,  epdo);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_dut("d8", S8, H8, T8, m8_act, m8_k, m8_word, m8_pdo,
                      {8'h00, pdo8}, busy8, done8, sck8, sdo8, scs8);
            check_dut("d16", S16, H16, T16, m16_act, m16_k, m16_word, m16_pdo,
                      pdo16, busy16, done16, sck16, sdo16, scs16);
        end
    end

    // Launch one 8-bit transfer and return the edge count to done.
    task automatic run8(input logic [7:0] w, input logic lb, output int lat);
        @(negedge clk);
        loop8  = lb;
        pdi8   = w;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pdi8   = ~w;
        lat    = 0;
        while (!done8 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat, dones;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chkw("rst_pdo8",  {8'h00, pdo8}, 16'h0000);
        chk1("rst_scs8",  scs8,  1'b0);
        chk1("rst_sck8",  sck8,  1'b0);
        chk1("rst_sdo8",  sdo8,  1'b0);
        chk1("rst_busy8", busy8, 1'b0);
        chk1("rst_done8", done8, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Slave replying 0x81 to 0xA5; pdi is disturbed after acceptance.
        run8(8'hA5, 1'b0, lat);
        chkw("lat_a5",      16'(lat), 16'd35);
        chkw("pdo_slave",   {8'h00, pdo8}, 16'h0081);
        chkw("slave_rx",    {8'h00, sl_rx}, 16'h00A5);
        chkw("sck_rises",   16'(sl_rises), 16'd8);

        // Loopback patterns.
        run8(8'h5A, 1'b1, lat);
        chkw("loop_5a", {8'h00, pdo8}, 16'h005A);
        run8(8'h00, 1'b1, lat);
        chkw("loop_00", {8'h00, pdo8}, 16'h0000);
        run8(8'hFF, 1'b1, lat);
        chkw("loop_ff", {8'h00, pdo8}, 16'h00FF);
        repeat (3) @(negedge clk);
        chkw("pdo_hold", {8'h00, pdo8}, 16'h00FF);

        // Start pulsed again during bit 3 is ignored.
        loop8 = 1'b1; pdi8 = 8'h3C; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (H8 + 1 + 2 * 3 * H8) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        repeat (2 * T8) begin
            @(negedge clk);
            if (done8) dones++;
        end
        chkw("ign_dones", 16'(dones), 16'd1);
        chkw("ign_pdo",   {8'h00, pdo8}, 16'h003C);

        // Start held high across done: back-to-back with one deselected cycle.
        pdi8 = 8'h96; start8 = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done8 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chkw("b2b_lat1", 16'(lat), 16'd35);
        chk1("b2b_gap_scs", scs8, 1'b0);
        chkw("b2b_pdo1", {8'h00, pdo8}, 16'h0096);
        @(negedge clk);
        chk1("b2b_restart_scs",  scs8,  1'b1);
        chk1("b2b_restart_busy", busy8, 1'b1);
        start8 = 1'b0;
        pdi8   = 8'h69;
        lat    = 0;
        while (!done8 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chkw("b2b_lat2", 16'(lat), 16'd35);
        chkw("b2b_pdo2", {8'h00, pdo8}, 16'h0096);

        // Reset during bit 5, with start asserted alongside it.
        pdi8 = 8'hC3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (H8 + 1 + 2 * 5 * H8) @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        chk1("abort_scs",  scs8,  1'b0);
        chk1("abort_sck",  sck8,  1'b0);
        chk1("abort_busy", busy8, 1'b0);
        chkw("abort_pdo",  {8'h00, pdo8}, 16'h0000);
        rst = 1'b0; start8 = 1'b0;
        dones = 0;
        repeat (2 * T8) begin
            @(negedge clk);
            if (done8) dones++;
        end
        chkw("abort_dones", 16'(dones), 16'd0);

        // 16-bit, half=1 loopback.
        @(negedge clk);
        pdi16 = 16'h8001; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        pdi16   = 16'h0000;
        lat     = 0;
        while (!done16 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chkw("lat16", 16'(lat), 16'd34);
        chkw("pdo16", pdo16, 16'h8001);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
